// File: rtl/handshake_upsizer_pkg.sv
// Shared handshake definitions: lane-counter sizing and the set of legal
// beats-per-word ratios for the upsizer.
package handshake_upsizer_pkg;

    localparam int RATIO_MIN = 32'sd2;
    localparam int RATIO_MAX = 32'sd4;

    function automatic int cnt_width(input int ratio);
        return (ratio > 32'sd1) ? $clog2(ratio) : 32'sd1;
    endfunction

    function automatic bit ratio_is_legal(input int ratio);
        return (ratio == RATIO_MIN) || (ratio == RATIO_MAX);
    endfunction

endpackage

// File: rtl/handshake_out_reg.sv
// Output word register: captures a packed word on load and holds it
// stable until the downstream side accepts it.
module handshake_out_reg #(
    parameter int WW = 16,
    parameter int KW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [WW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          ready,
    output logic          valid,
    output logic [WW-1:0] data,
    output logic [KW-1:0] keep,
    output logic          free
);

    logic          valid_r;
    logic [WW-1:0] data_r;
    logic [KW-1:0] keep_r;

    // Free when empty or draining this cycle, so a new word can follow with no bubble.
    assign free  = !valid_r || ready;
    assign valid = valid_r;
    assign data  = data_r;
    assign keep  = keep_r;

    // Word register: load wins over drain; otherwise hold contents while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {WW{1'b0}};
            keep_r  <= {KW{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            keep_r  <= load_keep;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/handshake_upsizer.sv
// Packs RATIO narrow beats into one wide word, with flush support for
// emitting a partially filled word.
module handshake_upsizer
    import handshake_upsizer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RATIO  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_pre_i,
    input  logic [DATA_W-1:0]       data_pre_i,
    output logic                    ready_pre_o,
    input  logic                    flush_i,
    output logic                    valid_post_o,
    output logic [DATA_W*RATIO-1:0] data_post_o,
    output logic [RATIO-1:0]        keep_post_o,
    input  logic                    ready_post_i
);

    localparam int WW = DATA_W * RATIO;
    localparam int CW = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 32'sd1);

    if (!ratio_is_legal(RATIO)) begin : g_bad_ratio
        $error("handshake_upsizer: RATIO must be 2 or 4");
    end

    logic [CW-1:0]    cnt_r;
    logic [WW-1:0]    lanes_r;
    logic             flush_pend_r;

    logic             accept_s;
    logic             complete_s;
    logic             flush_req_s;
    logic             out_free_s;
    logic [CW-1:0]    cnt_adv_s;
    logic [WW-1:0]    word_s;
    logic [RATIO-1:0] keep_part_s;
    logic             load_s;
    logic [RATIO-1:0] load_keep_s;
    logic [CW-1:0]    cnt_next_s;
    logic [WW-1:0]    lanes_next_s;
    logic             pend_next_s;

    // The last lane may only be accepted if the output register can take the word.
    assign ready_pre_o = !flush_pend_r && ((cnt_r != LAST_LANE) || out_free_s);
    assign accept_s    = valid_pre_i && ready_pre_o;
    assign complete_s  = accept_s && (cnt_r == LAST_LANE);
    assign flush_req_s = flush_i || flush_pend_r;

    // Lane view including this cycle's beat, plus the partial-word keep mask.
    always_comb begin
        word_s      = lanes_r;
        keep_part_s = {RATIO{1'b0}};
        if (accept_s) begin
            cnt_adv_s = complete_s ? {CW{1'b0}} : (cnt_r + CW'(1'b1));
        end else begin
            cnt_adv_s = cnt_r;
        end
        for (int k = 0; k < RATIO; k++) begin
            if (accept_s && (cnt_r == CW'(k))) begin
                word_s[k*DATA_W +: DATA_W] = data_pre_i;
            end else begin
                word_s[k*DATA_W +: DATA_W] = lanes_r[k*DATA_W +: DATA_W];
            end
            if (k < int'(cnt_adv_s)) begin
                keep_part_s[k] = 1'b1;
            end else begin
                keep_part_s[k] = 1'b0;
            end
        end
    end

    // Emission control: a full word outranks a flush; a blocked flush waits as pending.
    always_comb begin
        load_s       = 1'b0;
        load_keep_s  = {RATIO{1'b0}};
        cnt_next_s   = cnt_adv_s;
        lanes_next_s = word_s;
        pend_next_s  = flush_pend_r;
        if (complete_s) begin
            load_s       = 1'b1;
            load_keep_s  = {RATIO{1'b1}};
            lanes_next_s = {WW{1'b0}};
            pend_next_s  = 1'b0;
        end else if (flush_req_s && (cnt_adv_s != {CW{1'b0}})) begin
            if (out_free_s) begin
                load_s       = 1'b1;
                load_keep_s  = keep_part_s;
                cnt_next_s   = {CW{1'b0}};
                lanes_next_s = {WW{1'b0}};
                pend_next_s  = 1'b0;
            end else begin
                pend_next_s  = 1'b1;
            end
        end else begin
            pend_next_s = 1'b0;
        end
    end

    // Packing state; lanes are cleared on every emission so unused lanes read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= {CW{1'b0}};
            lanes_r      <= {WW{1'b0}};
            flush_pend_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_next_s;
            lanes_r      <= lanes_next_s;
            flush_pend_r <= pend_next_s;
        end
    end

    handshake_out_reg #(
        .WW (WW),
        .KW (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (word_s),
        .load_keep (load_keep_s),
        .ready     (ready_post_i),
        .valid     (valid_post_o),
        .data      (data_post_o),
        .keep      (keep_post_o),
        .free      (out_free_s)
    );

endmodule

// File: tb/tb_handshake_upsizer.sv
// Self-checking bench for handshake_upsizer (DATA_W=8, RATIO=2): directed
// vector table, hand-written reset/throughput sequences, randomized scoreboard.
module tb_handshake_upsizer;

    localparam int DW = 8;
    localparam int R  = 2;
    localparam int WW = DW * R;

    logic          clk;
    logic          rst_n;
    logic          valid_pre_i;
    logic [DW-1:0] data_pre_i;
    logic          ready_pre_o;
    logic          flush_i;
    logic          valid_post_o;
    logic [WW-1:0] data_post_o;
    logic [R-1:0]  keep_post_o;
    logic          ready_post_i;

    handshake_upsizer #(.DATA_W(DW), .RATIO(R)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_pre_i  (valid_pre_i),
        .data_pre_i   (data_pre_i),
        .ready_pre_o  (ready_pre_o),
        .flush_i      (flush_i),
        .valid_post_o (valid_post_o),
        .data_post_o  (data_post_o),
        .keep_post_o  (keep_post_o),
        .ready_post_i (ready_post_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          f;
        logic          rp;
        logic          e_rdy;
        logic          e_vld;
        logic [WW-1:0] e_data;
        logic [R-1:0]  e_keep;
    } vec_t;

    vec_t vecs[$];

    logic [DW-1:0] partial[$];
    logic [WW-1:0] exp_data_q[$];
    logic [R-1:0]  exp_keep_q[$];
    int            next_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [DW-1:0] d, input logic f, input logic rp,
                       input logic er, input logic ev, input logic [WW-1:0] ed, input logic [R-1:0] ek);
        vecs.push_back({v, d, f, rp, er, ev, ed, ek});
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic f, input logic rp);
        valid_pre_i  = v;
        data_pre_i   = d;
        flush_i      = f;
        ready_post_i = rp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pack the accepted beats, closing a word when full or on a non-empty flush.
    task automatic close_word();
        logic [WW-1:0] w = {WW{1'b0}};
        logic [R-1:0]  k = {R{1'b0}};
        for (int i = 0; i < partial.size(); i++) begin
            w[i*DW +: DW] = partial[i];
            k[i] = 1'b1;
        end
        exp_data_q.push_back(w);
        exp_keep_q.push_back(k);
        partial.delete();
    endtask

    task automatic observe();
        if (valid_post_o) begin
            if (exp_data_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)", data_post_o, $time);
            end else begin
                check("rand_data", 32'(data_post_o), 32'(exp_data_q[0]));
                check("rand_keep", 32'(keep_post_o), 32'(exp_keep_q[0]));
                if (ready_post_i) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_keep_q.pop_front());
                end
            end
        end
        if (valid_pre_i && ready_pre_o) begin
            partial.push_back(data_pre_i);
            next_beat++;
        end
        if (partial.size() == R) begin
            close_word();
        end else if (flush_i && (partial.size() > 0)) begin
            close_word();
        end
    endtask

    task automatic run_random(input int flush_mod);
        int cycles = 0;
        next_beat = 1;
        partial.delete();
        exp_data_q.delete();
        exp_keep_q.delete();
        while ((next_beat <= 200) && (cycles < 4000)) begin
            drive(($urandom_range(0, 9) < 7), DW'(next_beat),
                  (flush_mod != 0) && ($urandom_range(0, flush_mod - 1) == 0),
                  ($urandom_range(0, 9) < 6));
            @(negedge clk);
            observe();
            tick();
            cycles++;
        end
        check("rand_beats_accepted", 32'(next_beat), 32'd201);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        observe();
        tick();
        cycles = 0;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        while (((exp_data_q.size() > 0) || valid_post_o) && (cycles < 20)) begin
            @(negedge clk);
            observe();
            tick();
            cycles++;
        end
        check("rand_drain_left", 32'(exp_data_q.size()), 32'd0);
        check("rand_partial_left", 32'(partial.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Row order: v, d, flush, ready_post | ready_pre, valid_post, data, keep
        add(1, 8'h01, 0, 1, 1, 0, 16'h0000, 2'b00);
        add(1, 8'h02, 0, 1, 1, 0, 16'h0000, 2'b00);
        add(1, 8'h03, 0, 1, 1, 1, 16'h0201, 2'b11);
        add(1, 8'h04, 0, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 8'h00, 0, 1, 1, 1, 16'h0403, 2'b11);
        add(1, 8'h11, 0, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 8'h00, 1, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 8'h00, 0, 1, 1, 1, 16'h0011, 2'b01);
        add(0, 8'h00, 1, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 8'h00, 0, 1, 1, 0, 16'h0000, 2'b00);
        add(1, 8'h31, 0, 1, 1, 0, 16'h0000, 2'b00);
        add(1, 8'h32, 1, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 8'h00, 0, 1, 1, 1, 16'h3231, 2'b11);
        add(0, 8'h00, 0, 1, 1, 0, 16'h0000, 2'b00);
        add(1, 8'h41, 0, 0, 1, 0, 16'h0000, 2'b00);
        add(1, 8'h42, 0, 0, 1, 0, 16'h0000, 2'b00);
        add(1, 8'h21, 1, 0, 1, 1, 16'h4241, 2'b11);
        add(0, 8'h00, 0, 0, 0, 1, 16'h4241, 2'b11);
        add(1, 8'h99, 0, 0, 0, 1, 16'h4241, 2'b11);
        add(0, 8'h00, 1, 0, 0, 1, 16'h4241, 2'b11);
        add(0, 8'h00, 0, 1, 0, 1, 16'h4241, 2'b11);
        add(0, 8'h00, 0, 0, 1, 1, 16'h0021, 2'b01);
        add(0, 8'h00, 0, 1, 1, 1, 16'h0021, 2'b01);
        add(0, 8'h00, 0, 1, 1, 0, 16'h0000, 2'b00);

        // Reset state
        #12;
        check("rst_valid", 32'(valid_post_o), 32'd0);
        check("rst_data",  32'(data_post_o),  32'd0);
        check("rst_keep",  32'(keep_post_o),  32'd0);
        check("rst_ready", 32'(ready_pre_o),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vector table
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].rp);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(ready_pre_o), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_valid", i), 32'(valid_post_o), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                check($sformatf("vec%0d_data", i), 32'(data_post_o), 32'(vecs[i].e_data));
                check($sformatf("vec%0d_keep", i), 32'(keep_post_o), 32'(vecs[i].e_keep));
            end
            tick();
        end

        // Reset mid-word with a held output word and one pending lane
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("pre_rst_valid", 32'(valid_post_o), 32'd1);
        check("pre_rst_data",  32'(data_post_o),  32'h0201);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_post_o), 32'd0);
        check("async_rst_data",  32'(data_post_o),  32'd0);
        check("async_rst_keep",  32'(keep_post_o),  32'd0);
        check("async_rst_ready", 32'(ready_pre_o),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 8'h01, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h02, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("post_rst_valid", 32'(valid_post_o), 32'd1);
        check("post_rst_data",  32'(data_post_o),  32'h0201);
        check("post_rst_keep",  32'(keep_post_o),  32'h3);
        tick();

        // Continuous streaming: one beat per cycle, one word every RATIO cycles
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, DW'(8'hA0 + i), 1'b0, 1'b1);
            @(negedge clk);
            check($sformatf("stream%0d_ready", i), 32'(ready_pre_o), 32'd1);
            check($sformatf("stream%0d_valid", i), 32'(valid_post_o),
                  32'((i >= 2) && (i % 2 == 0)));
            if ((i >= 2) && (i % 2 == 0)) begin
                check($sformatf("stream%0d_data", i), 32'(data_post_o),
                      32'(((8'hA0 + i - 1) << 8) | (8'hA0 + i - 2)));
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        tick();

        // Randomized stalls against the packing model, first without then with flushes
        run_random(0);
        run_random(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
